// File: rtl/line_buffer_sequencer.sv
// Frame sequencer between a pixel stream, a sliding-window line buffer and a window consumer.
// Optional delivered-window counter on win_count is built when LB_SEQ_WIN_COUNT_EN is defined.
module line_buffer_sequencer #(
   parameter int FILTER_SIZE = -1,
   parameter int IMAGE_SIZE  = -1,
   parameter int STRIDE      = -1
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic in_valid,
   output logic in_ready,
   output logic buf_en,
   input  logic win_valid,
   output logic out_valid,
   input  logic out_ready,
   output logic busy,
   output logic frame_done,
   output logic [$clog2(((IMAGE_SIZE - FILTER_SIZE) / STRIDE + 1) *
                        ((IMAGE_SIZE - FILTER_SIZE) / STRIDE + 1)):0] win_count
);

   localparam int OUT_DIM = (IMAGE_SIZE - FILTER_SIZE) / STRIDE + 1;
   localparam int TOTAL   = IMAGE_SIZE * IMAGE_SIZE;
   localparam int WIN_W   = $clog2(OUT_DIM * OUT_DIM) + 1;
   localparam int PIX_W   = $clog2(TOTAL + 1);
   localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(TOTAL - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } state_t;

   state_t           state;
   logic [PIX_W-1:0] pix_cnt;
   logic             pending;
   logic             win_in;
   logic             win_take;

   // A pixel is only taken when the pending window slot is free or being emptied now,
   // so a window produced by this pixel always has somewhere to go.
   assign in_ready  = (state == RUN) && (!pending || out_ready);
   assign buf_en    = in_valid && in_ready;
   assign win_in    = buf_en && win_valid;
   assign win_take  = pending && out_ready;
   assign out_valid = pending;

   // NOTE: state is updated with non-blocking assignments and reset is sampled on the
   // clock edge, so every register here sees the same pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         pix_cnt    <= '0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state   <= RUN;
                  pix_cnt <= '0;
                  busy    <= 1'b1;
               end
            end
            RUN: begin
               if (buf_en) begin
                  pix_cnt <= pix_cnt + 1'b1;
                  if (pix_cnt == LAST_PIX) begin
                     state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (!pending) begin
                  state      <= DONE;
                  frame_done <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // A new window arriving while the old one is accepted keeps the slot full.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending <= 1'b0;
      end else if (win_in) begin
         pending <= 1'b1;
      end else if (win_take) begin
         pending <= 1'b0;
      end
   end

`ifdef LB_SEQ_WIN_COUNT_EN
   logic [WIN_W-1:0] win_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         win_cnt <= '0;
      end else if (state == IDLE && start) begin
         win_cnt <= '0;
      end else if (win_take) begin
         win_cnt <= win_cnt + 1'b1;
      end
   end

   assign win_count = win_cnt;
`else
   assign win_count = '0;
`endif

endmodule

// File: tb/tb_line_buffer_sequencer.sv
// Self-checking bench for line_buffer_sequencer: a per-cycle vector table plus frame-level
// sequences on a 4x4/3/1 instance and a 5x5/3/2 instance.
module tb_line_buffer_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       start     [2];
   logic       in_valid  [2];
   logic       out_ready [2];
   logic       win_valid [2];
   logic       in_ready  [2];
   logic       buf_en    [2];
   logic       out_valid [2];
   logic       busy      [2];
   logic       frame_done[2];
   logic [2:0] win_count [2];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   line_buffer_sequencer #(.FILTER_SIZE(3), .IMAGE_SIZE(4), .STRIDE(1)) dut_a (
      .clk(clk), .rst(rst), .start(start[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .buf_en(buf_en[0]), .win_valid(win_valid[0]), .out_valid(out_valid[0]),
      .out_ready(out_ready[0]), .busy(busy[0]), .frame_done(frame_done[0]),
      .win_count(win_count[0])
   );

   line_buffer_sequencer #(.FILTER_SIZE(3), .IMAGE_SIZE(5), .STRIDE(2)) dut_b (
      .clk(clk), .rst(rst), .start(start[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .buf_en(buf_en[1]), .win_valid(win_valid[1]), .out_valid(out_valid[1]),
      .out_ready(out_ready[1]), .busy(busy[1]), .frame_done(frame_done[1]),
      .win_count(win_count[1])
   );

   typedef struct {
      logic st, iv, ordy, wv;
      logic e_ir, e_be, e_ov, e_busy, e_fd;
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Line-buffer model: window complete on pixel k of an img x img raster.
   function automatic logic win_at(input int img, input int f, input int s, input int k);
      int r, c;
      if (k >= img * img) return 1'b0;
      r = k / img;
      c = k % img;
      return (r >= f - 1) && (c >= f - 1) && ((r - f + 1) % s == 0) && ((c - f + 1) % s == 0);
   endfunction

   function automatic int model_windows(input int img, input int f, input int s);
      int n = 0;
      for (int k = 0; k < img * img; k++) if (win_at(img, f, s, k)) n++;
      return n;
   endfunction

   // mode 0: continuous; 1: out_ready held low 5 cycles after last pixel; 2: bursty both sides
   task automatic run_frame(input int d, input int img, input int f, input int s,
                            input int mode, input int exp_gap);
      int  total = img * img;
      int  sent = 0, wins = 0, fds = 0, cyc = 0, hold = 0;
      int  last_t = -1, fd_t = -1;
      int  exp_wins = model_windows(img, f, s);
      logic iv, ordy;
      @(negedge clk);
      start[d] = 1'b1; in_valid[d] = 1'b0; out_ready[d] = 1'b1; win_valid[d] = 1'b0;
      @(negedge clk);
      start[d] = 1'b0;
      #1;
      check($sformatf("f%0d_busy_after_start", d), busy[d], 1'b1);
      check($sformatf("f%0d_win_count_cleared", d), win_count[d], 3'd0);
      while (fds == 0 && cyc < 300) begin
         case (mode)
            1: begin iv = (sent < total); ordy = !(sent == total && hold < 5); end
            2: begin iv = (sent < total) && (cyc % 4 != 1); ordy = (cyc % 3 != 0); end
            default: begin iv = (sent < total); ordy = 1'b1; end
         endcase
         in_valid[d] = iv; out_ready[d] = ordy; win_valid[d] = win_at(img, f, s, sent);
         #1;
         if (sent == total) check($sformatf("f%0d_drain_in_ready", d), in_ready[d], 1'b0);
         check($sformatf("f%0d_buf_en", d), buf_en[d], iv && in_ready[d]);
         if (out_valid[d] && !ordy) check($sformatf("f%0d_no_drop", d), in_ready[d], 1'b0);
         if (mode == 1 && !ordy) begin
            check("hold_pending", out_valid[d], 1'b1);
            check("hold_busy", busy[d], 1'b1);
            hold++;
         end
         if (buf_en[d]) begin
            sent++;
            if (sent == total) last_t = cyc;
         end
         if (out_valid[d] && ordy) wins++;
         if (frame_done[d]) begin
            fds++;
            fd_t = cyc;
            check($sformatf("f%0d_busy_in_done", d), busy[d], 1'b1);
         end
         cyc++;
         @(negedge clk);
      end
      in_valid[d] = 1'b0; win_valid[d] = 1'b0; out_ready[d] = 1'b1;
      check($sformatf("f%0d_frame_done_seen", d), fds, 1);
      check($sformatf("f%0d_pixels", d), sent, total);
      check($sformatf("f%0d_windows", d), wins, exp_wins);
      if (exp_gap > 0) check($sformatf("f%0d_done_latency", d), fd_t - last_t, exp_gap);
      for (int i = 0; i < 3; i++) begin
         #1;
         check($sformatf("f%0d_idle_frame_done", d), frame_done[d], 1'b0);
         check($sformatf("f%0d_idle_busy", d), busy[d], 1'b0);
         @(negedge clk);
      end
      #1;
`ifdef LB_SEQ_WIN_COUNT_EN
      check($sformatf("f%0d_win_count", d), win_count[d], exp_wins);
`else
      check($sformatf("f%0d_win_count", d), win_count[d], 3'd0);
`endif
   endtask

   task automatic reset_pulse();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      in_valid[0] = 1'b0; win_valid[0] = 1'b0;
      #1;
      check("rst_busy", busy[0], 1'b0);
      check("rst_out_valid", out_valid[0], 1'b0);
      check("rst_in_ready", in_ready[0], 1'b0);
      check("rst_buf_en", buf_en[0], 1'b0);
      check("rst_win_count", win_count[0], 3'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1;
         check("rst_no_frame_done", frame_done[0], 1'b0);
      end
   endtask

   initial begin
      int sent;
      int budget;
      rst = 1'b1;
      for (int d = 0; d < 2; d++) begin
         start[d] = 1'b0; in_valid[d] = 1'b0; out_ready[d] = 1'b0; win_valid[d] = 1'b0;
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;

      //          st  iv  or  wv   ir  be  ov  bsy fd
      vecs[0]  = '{0,  0,  0,  0,   0,  0,  0,  0,  0};
      vecs[1]  = '{0,  1,  1,  1,   0,  0,  0,  0,  0};
      vecs[2]  = '{1,  0,  0,  0,   0,  0,  0,  0,  0};
      vecs[3]  = '{0,  0,  0,  0,   1,  0,  0,  1,  0};
      vecs[4]  = '{1,  0,  0,  0,   1,  0,  0,  1,  0};
      vecs[5]  = '{0,  1,  0,  1,   1,  1,  0,  1,  0};
      vecs[6]  = '{0,  1,  0,  0,   0,  0,  1,  1,  0};
      vecs[7]  = '{0,  1,  0,  0,   0,  0,  1,  1,  0};
      vecs[8]  = '{0,  1,  1,  1,   1,  1,  1,  1,  0};
      vecs[9]  = '{0,  0,  1,  0,   1,  0,  1,  1,  0};
      vecs[10] = '{0,  0,  0,  0,   1,  0,  0,  1,  0};

      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         start[0] = vecs[i].st; in_valid[0] = vecs[i].iv;
         out_ready[0] = vecs[i].ordy; win_valid[0] = vecs[i].wv;
         #1;
         check($sformatf("vec%0d_in_ready", i), in_ready[0], vecs[i].e_ir);
         check($sformatf("vec%0d_buf_en", i), buf_en[0], vecs[i].e_be);
         check($sformatf("vec%0d_out_valid", i), out_valid[0], vecs[i].e_ov);
         check($sformatf("vec%0d_busy", i), busy[0], vecs[i].e_busy);
         check($sformatf("vec%0d_frame_done", i), frame_done[0], vecs[i].e_fd);
      end
      @(negedge clk);
      start[0] = 1'b0; in_valid[0] = 1'b0; out_ready[0] = 1'b0; win_valid[0] = 1'b0;
      #1;
`ifdef LB_SEQ_WIN_COUNT_EN
      check("vec_win_count", win_count[0], 3'd2);
`else
      check("vec_win_count", win_count[0], 3'd0);
`endif

      reset_pulse();
      run_frame(0, 4, 3, 1, 0, 3);
      run_frame(1, 5, 3, 2, 0, 3);
      run_frame(0, 4, 3, 1, 1, 8);
      run_frame(0, 4, 3, 1, 2, 0);

      // Abandon a frame after 7 pixels, then run a clean one.
      @(negedge clk);
      start[0] = 1'b1; out_ready[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      sent = 0;
      budget = 0;
      while (sent < 7 && budget < 50) begin
         in_valid[0] = 1'b1;
         win_valid[0] = win_at(4, 3, 1, sent);
         #1;
         if (buf_en[0]) sent++;
         budget++;
         @(negedge clk);
      end
      check("abort_pixels_sent", sent, 7);
      in_valid[0] = 1'b1;
      reset_pulse();
      run_frame(0, 4, 3, 1, 0, 3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
